grid_port_arbiter: RTL
======================

# grid_port_arbiter

Round-robin arbiter and sequencer that shares the single-port grid RAM between up to `N_REQ` placement engines. It serialises read, write and atomic claim requests so that concurrent engines cannot both take the same grid cell. A claim reads a cell and, only if the cell holds `EMPTY`, writes the requester's node id into it in the same transaction. The block sits between the placement engines and the `memoryRAM` grid instance; the memory has a one-cycle registered read.

## Interface
- `N_REQ`, 4, number of requesters.
- `ADDR_W`, 7, grid address width.
- `DATA_W`, 32, grid word width.
- `DEPTH`, 81, valid cells (n*n with n=9); addresses >= `DEPTH` are rejected.
- `EMPTY`, 32'hFFFFFFFF, free-cell marker (-1).

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `req_valid`  in  N_REQ  request pending, one bit per requester; held until that requester's `rsp_valid`.
- `req_op`  in  2*N_REQ  per-requester op: 00 read, 01 write, 10 claim, 11 reserved.
- `req_addr`  in  N_REQ*ADDR_W  per-requester cell address.
- `req_wdata`  in  N_REQ*DATA_W  per-requester write/claim data.
- `rsp_valid`  out  N_REQ  one-cycle completion pulse to the granted requester.
- `rsp_data`  out  DATA_W  cell contents read (read/claim).
- `rsp_ok`  out  1  1 = success; 0 = claim lost, out of range, or reserved op.
- `mem_re`, `mem_we`  out  1  grid RAM strobes.
- `mem_addr`  out  ADDR_W  grid RAM address.
- `mem_wdata`  out  DATA_W  grid RAM write data.
- `mem_rdata`  in  DATA_W  grid RAM read data; valid the cycle after `mem_re` is visible.
- `claim_fail_cnt`  out  16  number of lost claims, saturating.

## Operation
- All outputs are registered. On reset: all outputs are 0, state is IDLE, `rr_ptr` is 0, `claim_fail_cnt` is 0.
- IDLE:
  - Pick the first requester with `req_valid` set, searching from `rr_ptr` upward with wrap. Latch its index, op, addr and wdata.
  - Read/claim with addr < `DEPTH`: set `mem_re`.
  - Write with addr < `DEPTH`: set `mem_we` and `mem_wdata`.
  - Out-of-range address or op 11: no memory strobe; the request is flagged as rejected.
  - Go to MEM.
- MEM:
  - Clear the strobes.
  - Write or rejected request: set `rsp_valid[g]`; `rsp_ok` is 1 for a good write and 0 if rejected; go to RESP.
  - Otherwise: go to EVAL.
- EVAL: `rsp_data` <= `mem_rdata`, `rsp_valid[g]` <= 1.
  - Read: `rsp_ok` = 1.
  - Claim with `mem_rdata == EMPTY`: set `mem_we` to the same addr with the latched wdata; `rsp_ok` = 1.
  - Claim with `mem_rdata != EMPTY`: `rsp_ok` = 0 and `claim_fail_cnt` increments, saturating at 16'hFFFF.
  - Go to RESP.
- RESP:
  - The response pulse and any claim write are visible this cycle.
  - Clear `rsp_valid` and `mem_we`.
  - `rr_ptr` <= (g+1) mod `N_REQ`.
  - Go to IDLE.
- One transaction is in flight at a time, which makes claims atomic. `rsp_data` holds its value until the next EVAL.

## Timing
- Latency, counted from the IDLE cycle T in which the request is sampled:
  - write or rejected request: `rsp_valid` at T+2, next arbitration at T+3;
  - read or claim: `rsp_valid` at T+3, next arbitration at T+4.
- Memory strobes are visible at T+1; a claim write is visible at T+3.
- A requester must drop or change `req_valid` on the edge that ends its `rsp_valid` cycle. IDLE never samples during RESP, so there is no double grant.
- Reset in any state: the transaction is abandoned, with no `rsp_valid` and no `mem_we` on the following cycle.
- A request raised during a busy cycle waits; no request is lost while its `req_valid` stays high.

## Structure
- Shared include `grid_defs.vh`: op encodings, `EMPTY`, state encodings (IDLE=0, MEM=1, EVAL=2, RESP=3).
- Sub-module `rr_pick`: a combinational priority picker that returns the index and found flag from `req_valid` and `rr_ptr`.

## Test plan
- Read: grid[5]=-1; requester 0 reads addr 5 at T -> `rsp_valid`=4'b0001 at T+3, `rsp_data`=32'hFFFFFFFF, `rsp_ok`=1.
- Claim race: requesters 1 and 2 claim addr 40 in the same cycle (wdata 7 and 9), `rr_ptr`=0:
  - requester 1 gets `rsp_ok`=1 and `rsp_data`=FFFFFFFF;
  - requester 2 gets `rsp_ok`=0 and `rsp_data`=7;
  - grid[40]=7 and `claim_fail_cnt`=1.
- Fairness: all 4 requesters hold reads continuously -> grant order 0,1,2,3,0, with `rsp_valid` pulses 4 cycles apart.
- Out of range: write to addr 81 -> `rsp_ok`=0 at T+2, `mem_we` never asserted, grid unchanged.
- Reset mid-claim: assert reset in EVAL with an empty cell -> no `rsp_valid`, no `mem_we`, cell still -1, outputs 0.
- Ordering: requester 0 writes 3 to addr 10, then requester 3 reads addr 10 -> `rsp_data`=3, `rsp_ok`=1.

Source files
------------

// File: rtl/grid_port_arbiter_pkg.sv
// Shared encodings for the grid RAM port arbiter.
package grid_port_arbiter_pkg;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_CLAIM = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MEM  = 2'd1,
        ST_EVAL = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    localparam logic [31:0] GRID_EMPTY = 32'hFFFF_FFFF;

endpackage

// File: rtl/grid_port_arbiter_rr_pick.sv
// Round-robin priority picker: first set bit at or above ptr, with wrap.
module grid_port_arbiter_rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] valid_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             found_o
);

    // Scan from the far end so the nearest candidate wins last.
    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (valid_i[(int'(ptr_i) + i) % N_REQ]) begin
                idx_o   = IDX_W'((int'(ptr_i) + i) % N_REQ);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/grid_port_arbiter.sv
// Serialises read/write/claim requests from the placement engines
// onto the single-port grid RAM; one transaction in flight at a time.
module grid_port_arbiter
    import grid_port_arbiter_pkg::*;
#(
    parameter int                N_REQ  = 4,
    parameter int                ADDR_W = 7,
    parameter int                DATA_W = 32,
    parameter int                DEPTH  = 81,
    parameter logic [DATA_W-1:0] EMPTY  = DATA_W'(GRID_EMPTY)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [2*N_REQ-1:0]        req_op,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    input  logic [N_REQ*DATA_W-1:0]   req_wdata,
    output logic [N_REQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      rsp_ok,
    output logic                      mem_re,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic [DATA_W-1:0]         mem_rdata,
    output logic [15:0]               claim_fail_cnt
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    state_e             state_q, state_d;
    op_e                op_q, op_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   gnt_q, gnt_d;
    logic               rej_q, rej_d;
    logic [N_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
    logic               rsp_ok_q, rsp_ok_d;
    logic               mem_re_q, mem_re_d;
    logic               mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
    logic [15:0]        fail_cnt_q, fail_cnt_d;

    logic [IDX_W-1:0]   pick_idx;
    logic               pick_found;
    op_e                sel_op;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;
    logic               sel_rej;
    logic [N_REQ-1:0]   gnt_onehot;

    grid_port_arbiter_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .valid_i (req_valid),
        .ptr_i   (rr_ptr_q),
        .idx_o   (pick_idx),
        .found_o (pick_found)
    );

    assign sel_op    = op_e'(req_op[pick_idx*2 +: 2]);
    assign sel_addr  = req_addr[pick_idx*ADDR_W +: ADDR_W];
    assign sel_wdata = req_wdata[pick_idx*DATA_W +: DATA_W];
    assign sel_rej   = ({1'b0, sel_addr} >= DEPTH_C) || (sel_op == OP_RSVD);

    always_comb begin
        gnt_onehot        = '0;
        gnt_onehot[gnt_q] = 1'b1;
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        rr_ptr_d    = rr_ptr_q;
        gnt_d       = gnt_q;
        rej_d       = rej_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_ok_d    = rsp_ok_q;
        mem_re_d    = mem_re_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        fail_cnt_d  = fail_cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    gnt_d       = pick_idx;
                    op_d        = sel_op;
                    rej_d       = sel_rej;
                    mem_addr_d  = sel_addr;
                    mem_wdata_d = sel_wdata;
                    mem_re_d    = !sel_rej && (sel_op != OP_WRITE);
                    mem_we_d    = !sel_rej && (sel_op == OP_WRITE);
                    state_d     = ST_MEM;
                end
            end
            ST_MEM: begin
                mem_re_d = 1'b0;
                mem_we_d = 1'b0;
                if (rej_q || op_q == OP_WRITE) begin
                    rsp_valid_d = gnt_onehot;
                    rsp_ok_d    = !rej_q;
                    state_d     = ST_RESP;
                end else begin
                    state_d = ST_EVAL;
                end
            end
            ST_EVAL: begin
                rsp_data_d  = mem_rdata;
                rsp_valid_d = gnt_onehot;
                rsp_ok_d    = 1'b1;
                // Claim write-back rides in the same transaction: atomic.
                if (op_q == OP_CLAIM) begin
                    if (mem_rdata == EMPTY) begin
                        mem_we_d = 1'b1;
                    end else begin
                        rsp_ok_d = 1'b0;
                        if (fail_cnt_q != 16'hFFFF) begin
                            fail_cnt_d = fail_cnt_q + 16'd1;
                        end
                    end
                end
                state_d = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid_d = '0;
                mem_we_d    = 1'b0;
                rr_ptr_d    = (gnt_q == IDX_W'(N_REQ - 1)) ? '0 : gnt_q + 1'b1;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_READ;
            rr_ptr_q    <= '0;
            gnt_q       <= '0;
            rej_q       <= 1'b0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_ok_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            fail_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            rr_ptr_q    <= rr_ptr_d;
            gnt_q       <= gnt_d;
            rej_q       <= rej_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_ok_q    <= rsp_ok_d;
            mem_re_q    <= mem_re_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            fail_cnt_q  <= fail_cnt_d;
        end
    end

    assign rsp_valid      = rsp_valid_q;
    assign rsp_data       = rsp_data_q;
    assign rsp_ok         = rsp_ok_q;
    assign mem_re         = mem_re_q;
    assign mem_we         = mem_we_q;
    assign mem_addr       = mem_addr_q;
    assign mem_wdata      = mem_wdata_q;
    assign claim_fail_cnt = fail_cnt_q;

endmodule
